// File: rtl/rpspmc_readback_pkg.sv
// Shared FSM/requester types and the readback address map for the readback mux arbiter.
package rpspmc_readback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_CAPTURE
  } rb_state_e;

  typedef enum logic {
    REQ_HOST,
    REQ_SCAN
  } req_sel_e;

  localparam logic [31:0] RB_ADDR_Z            = 32'd100001;
  localparam logic [31:0] RB_ADDR_BIAS         = 32'd100002;
  localparam logic [31:0] RB_ADDR_GVPBIAS      = 32'd100003;
  localparam logic [31:0] RB_ADDR_AD463X       = 32'd100100;
  localparam logic [31:0] RB_ADDR_X            = 32'd100999;
  localparam logic [31:0] RB_ADDR_TIMING_TEST  = 32'd101999;
  localparam logic [31:0] RB_ADDR_TIMING_RESET = 32'd102000;
  localparam logic [31:0] RB_ADDR_VERSION      = 32'd199997;

endpackage

// File: rtl/readback_period_timer.sv
// Scan period down-counter: reloads on enable rise and on expiry, pulses expire for one cycle,
// and counts (saturating) expiries that land while a round is already pending. No backpressure.
module readback_period_timer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        pending,
  output logic        expire,
  output logic [15:0] overrun
);

  logic        en_q, en_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] overrun_q, overrun_d;

  // A zero period never expires; back-to-back rounds are handled by the arbiter instead.
  assign expire  = enable && en_q && (period != 32'd0) && (cnt_q <= 32'd1);
  assign overrun = overrun_q;

  always_comb begin
    en_d      = enable;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    if (!enable) begin
      cnt_d = 32'd0;
    end else if (!en_q || expire) begin
      cnt_d = period;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end
    if (expire && pending && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q      <= 1'b0;
      cnt_q     <= 32'd0;
      overrun_q <= 16'd0;
    end else begin
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: rtl/readback_scan_arbiter.sv
// Shares the readback mux between a one-shot host request (fixed priority) and a periodic slot scanner.
// Latency: address on config_addr 1 cycle after grant, capture after SETTLE_CYCLES more, host_ack next cycle.
module readback_scan_arbiter
  import rpspmc_readback_pkg::*;
#(
  parameter int          NUM_SLOTS     = 4,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] IDLE_ADDR     = 32'd0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [31:0]            host_addr,
  input  logic                   host_req,
  output logic                   host_ack,
  output logic [31:0]            host_dataA,
  output logic [31:0]            host_dataB,
  input  logic                   scan_enable,
  input  logic [31:0]            scan_period,
  input  logic [NUM_SLOTS*32-1:0] scan_addr_tbl,
  output logic [31:0]            config_addr,
  input  logic [31:0]            gpio_dataA,
  input  logic [31:0]            gpio_dataB,
  output logic [NUM_SLOTS*32-1:0] snap_dataA,
  output logic [NUM_SLOTS*32-1:0] snap_dataB,
  output logic [NUM_SLOTS-1:0]   snap_valid,
  output logic [31:0]            scan_round,
  output logic [15:0]            scan_overrun,
  output logic                   busy
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  rb_state_e              state_q, state_d;
  req_sel_e               sel_q, sel_d;
  logic [SLOT_W-1:0]      sel_slot_q, sel_slot_d;
  logic [SLOT_W-1:0]      cur_slot_q, cur_slot_d;
  logic [CNT_W-1:0]       settle_q, settle_d;
  logic [31:0]            lat_addr_q, lat_addr_d;
  logic [31:0]            config_addr_q, config_addr_d;
  logic                   busy_q, busy_d;
  logic                   host_ack_q, host_ack_d;
  logic [31:0]            host_a_q, host_a_d, host_b_q, host_b_d;
  logic [NUM_SLOTS*32-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [NUM_SLOTS-1:0]   snap_valid_q, snap_valid_d;
  logic [31:0]            scan_round_q, scan_round_d;
  logic                   pending_q, pending_d;
  logic                   round_done;
  logic                   expire;

  readback_period_timer u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .enable  (scan_enable),
    .period  (scan_period),
    .pending (pending_q),
    .expire  (expire),
    .overrun (scan_overrun)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    sel_slot_d    = sel_slot_q;
    cur_slot_d    = cur_slot_q;
    settle_d      = settle_q;
    lat_addr_d    = lat_addr_q;
    config_addr_d = config_addr_q;
    busy_d        = busy_q;
    host_ack_d    = 1'b0;
    host_a_d      = host_a_q;
    host_b_d      = host_b_q;
    snap_a_d      = snap_a_q;
    snap_b_d      = snap_b_q;
    snap_valid_d  = snap_valid_q;
    scan_round_d  = scan_round_q;
    pending_d     = pending_q;
    round_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host_req) begin
          state_d    = ST_SETUP;
          sel_d      = REQ_HOST;
          lat_addr_d = host_addr;
          busy_d     = 1'b1;
        end else if (pending_q && scan_enable) begin
          state_d    = ST_SETUP;
          sel_d      = REQ_SCAN;
          sel_slot_d = cur_slot_q;
          busy_d     = 1'b1;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cur_slot_q == SLOT_W'(i)) lat_addr_d = scan_addr_tbl[32*i +: 32];
          end
        end
      end
      ST_SETUP: begin
        config_addr_d = lat_addr_q;
        settle_d      = SETTLE_LOAD;
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_CAPTURE;
        else                settle_d = settle_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        state_d       = ST_IDLE;
        config_addr_d = IDLE_ADDR;
        busy_d        = 1'b0;
        if (sel_q == REQ_HOST) begin
          host_ack_d = 1'b1;
          host_a_d   = gpio_dataA;
          host_b_d   = gpio_dataB;
        end else begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel_slot_q == SLOT_W'(i)) begin
              snap_a_d[32*i +: 32] = gpio_dataA;
              snap_b_d[32*i +: 32] = gpio_dataB;
              snap_valid_d[i]      = 1'b1;
            end
          end
          // Only advance if this capture still belongs to the round in progress.
          if (sel_slot_q == cur_slot_q) begin
            if (cur_slot_q == LAST_SLOT) begin
              round_done   = 1'b1;
              cur_slot_d   = '0;
              scan_round_d = scan_round_q + 32'd1;
            end else begin
              cur_slot_d = cur_slot_q + SLOT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (round_done) pending_d = 1'b0;
    if (expire || (scan_enable && (scan_period == 32'd0))) pending_d = 1'b1;
    // Disabling abandons the round; the in-flight capture still lands its data but not its flag.
    if (!scan_enable) begin
      pending_d    = 1'b0;
      cur_slot_d   = '0;
      snap_valid_d = '0;
      scan_round_d = scan_round_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      sel_q         <= REQ_HOST;
      sel_slot_q    <= '0;
      cur_slot_q    <= '0;
      settle_q      <= '0;
      lat_addr_q    <= '0;
      config_addr_q <= IDLE_ADDR;
      busy_q        <= 1'b0;
      host_ack_q    <= 1'b0;
      host_a_q      <= '0;
      host_b_q      <= '0;
      snap_a_q      <= '0;
      snap_b_q      <= '0;
      snap_valid_q  <= '0;
      scan_round_q  <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      sel_slot_q    <= sel_slot_d;
      cur_slot_q    <= cur_slot_d;
      settle_q      <= settle_d;
      lat_addr_q    <= lat_addr_d;
      config_addr_q <= config_addr_d;
      busy_q        <= busy_d;
      host_ack_q    <= host_ack_d;
      host_a_q      <= host_a_d;
      host_b_q      <= host_b_d;
      snap_a_q      <= snap_a_d;
      snap_b_q      <= snap_b_d;
      snap_valid_q  <= snap_valid_d;
      scan_round_q  <= scan_round_d;
      pending_q     <= pending_d;
    end
  end

  assign config_addr = config_addr_q;
  assign busy        = busy_q;
  assign host_ack    = host_ack_q;
  assign host_dataA  = host_a_q;
  assign host_dataB  = host_b_q;
  assign snap_dataA  = snap_a_q;
  assign snap_dataB  = snap_b_q;
  assign snap_valid  = snap_valid_q;
  assign scan_round  = scan_round_q;

endmodule
